// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_pkg: glyph table, slot type and prescaler divisor helper for the 7-segment scan controller
package seg7_pkg;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef logic [1:0] slot_t;
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: valid/ready port carrying the 32-bit display word
interface seg7_scan_ctrl_if;
  logic        upd_valid;
  logic [31:0] upd_data;
  logic        upd_ready;
  modport master (output upd_valid, upd_data, input upd_ready);
  modport slave (input upd_valid, upd_data, output upd_ready);
endinterface

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// seg7_hex_decode: nibble to {g,f,e,d,c,b,a} segments, forced dark when blank
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: two-bank 4-digit multiplexed display driver with frame-aligned shadow updates
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits per bank.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  seg7_scan_ctrl_if.slave         upd,
  output logic [7:0]              digits,
  output logic [6:0]              digit_led_1,
  output logic [6:0]              digit_led_2,
  output logic                    frame_tick
);
  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  if (DIV < DEAD_CYCLES + 1) begin : g_cfg_err
    $fatal(1, "seg7_scan_ctrl: prescaler divisor shorter than dead time");
  end
  logic [PW-1:0] presc;
  slot_t         slot, slot_nxt;
  logic [31:0]   shadow, shown, shown_nxt;
  logic          pending, pending_nxt, wrap, accept;
  logic [3:0]    nib_1, nib_2;
  logic          blank_1, blank_2;
  logic [6:0]    seg_1, seg_2;
  assign wrap        = presc == PW'(DIV - 1);
  assign accept      = upd.upd_valid & upd.upd_ready;
  assign slot_nxt    = wrap ? slot + 2'd1 : slot;
  assign shown_nxt   = frame_tick & pending ? shadow : shown;
  assign pending_nxt = accept | (pending & ~frame_tick);
  // segments are decoded from next-state slot/shown so they change on the same edge as the slot
  assign nib_1 = shown_nxt[{slot_nxt, 2'b00} +: 4];
  assign nib_2 = shown_nxt[{1'b1, slot_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_1 = slot_nxt != 2'd0 && (shown_nxt[15:0] >> {slot_nxt, 2'b00}) == 16'd0;
  assign blank_2 = slot_nxt != 2'd0 && (shown_nxt[31:16] >> {slot_nxt, 2'b00}) == 16'd0;
`else
  assign blank_1 = 1'b0;
  assign blank_2 = 1'b0;
`endif
  seg7_hex_decode u_dec_1 (.nib(nib_1), .blank(blank_1), .seg(seg_1));
  seg7_hex_decode u_dec_2 (.nib(nib_2), .blank(blank_2), .seg(seg_2));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc         <= '0;
      slot          <= '0;
      shadow        <= '0;
      shown         <= '0;
      pending       <= 1'b0;
      upd.upd_ready <= 1'b1;
      digits        <= '0;
      digit_led_1   <= '0;
      digit_led_2   <= '0;
      frame_tick    <= 1'b0;
    end else begin
      presc         <= wrap ? '0 : presc + 1'b1;
      slot          <= slot_nxt;
      shown         <= shown_nxt;
      pending       <= pending_nxt;
      upd.upd_ready <= ~pending_nxt;
      if (accept) shadow <= upd.upd_data;
      digits        <= presc < PW'(DEAD_CYCLES) ? 8'h00 : {2{4'b0001 << slot}};
      digit_led_1   <= seg_1;
      digit_led_2   <= seg_2;
      frame_tick    <= slot == 2'd3 && presc == PW'(DIV - 2);
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed cycle-exact checks of scan timing, frame-aligned updates and reset
module tb_seg7_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] digits;
  logic [6:0] led_1, led_2;
  logic       frame_tick;
  int         n_chk = 0;
  int         n_bad = 0;
  int         cyc = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h00;
  localparam logic [6:0] E6_1 [4] = '{7'h3F, 7'h77, 7'h00, 7'h00};
  localparam logic [6:0] E6_2 [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
`else
  localparam logic [6:0] ZB = 7'h3F;
  localparam logic [6:0] E6_1 [4] = '{7'h3F, 7'h77, 7'h3F, 7'h3F};
  localparam logic [6:0] E6_2 [4] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif
  localparam logic [7:0] DIG_T1 [17] = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h00, 8'h22, 8'h22,
                                         8'h22, 8'h00, 8'h44, 8'h44, 8'h44, 8'h00, 8'h88, 8'h88, 8'h88};
  localparam logic [6:0] E2_1 [4] = '{7'h71, 7'h79, 7'h5E, 7'h39};
  localparam logic [6:0] E2_2 [4] = '{7'h7C, 7'h77, 7'h6F, 7'h7F};
  seg7_scan_ctrl_if upd ();
  seg7_scan_ctrl #(.CLK_HZ(400), .SCAN_HZ(100), .DEAD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .upd(upd), .digits(digits),
    .digit_led_1(led_1), .digit_led_2(led_2), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask
  initial begin
    upd.upd_valid = 1'b0;
    upd.upd_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 8'h00);
    chk("rst_led1", led_1, 7'h00);
    chk("rst_led2", led_2, 7'h00);
    chk("rst_ready", upd.upd_ready, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      step_to(k);
      chk("t1_digits", digits, DIG_T1[k]);
      chk("t1_led1", led_1, (k / 4) % 4 == 0 ? 7'h3F : ZB);
      chk("t1_led2", led_2, (k / 4) % 4 == 0 ? 7'h3F : ZB);
      chk("t1_tick", frame_tick, k == 15);
    end
    step_to(20);
    upd.upd_valid = 1'b1;
    upd.upd_data  = 32'h89AB_CDEF;
    step_to(21);
    chk("t2_ready_drop", upd.upd_ready, 1'b0);
    chk("t2_led1_old", led_1, ZB);
    upd.upd_valid = 1'b0;
    upd.upd_data  = 32'hDEAD_BEEF;
    step_to(31);
    chk("t2_tick", frame_tick, 1'b1);
    chk("t2_ready_hold", upd.upd_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_to(32 + 4 * i);
      chk("t2_led1", led_1, E2_1[i]);
      chk("t2_led2", led_2, E2_2[i]);
      if (i == 0) chk("t2_ready_back", upd.upd_ready, 1'b1);
    end
    step_to(45);
    upd.upd_valid = 1'b1;
    upd.upd_data  = 32'h1111_1111;
    step_to(46);
    chk("t3_ready_a", upd.upd_ready, 1'b0);
    upd.upd_data  = 32'h2222_2222;
    step_to(47);
    chk("t3_stall", upd.upd_ready, 1'b0);
    chk("t3_old", led_1, 7'h39);
    step_to(48);
    chk("t3_first_led1", led_1, 7'h06);
    chk("t3_first_led2", led_2, 7'h06);
    chk("t3_ready_b", upd.upd_ready, 1'b1);
    step_to(49);
    chk("t3_accept2", upd.upd_ready, 1'b0);
    upd.upd_valid = 1'b0;
    step_to(63);
    chk("t3_first_hold", led_1, 7'h06);
    chk("t3_first_hold2", led_2, 7'h06);
    step_to(64);
    chk("t3_second_led1", led_1, 7'h5B);
    chk("t3_second_led2", led_2, 7'h5B);
    step_to(79);
    chk("t4_tick", frame_tick, 1'b1);
    chk("t4_ready", upd.upd_ready, 1'b1);
    upd.upd_valid = 1'b1;
    upd.upd_data  = 32'h4444_4444;
    step_to(80);
    chk("t4_ready_drop", upd.upd_ready, 1'b0);
    chk("t4_old_s0", led_1, 7'h5B);
    upd.upd_valid = 1'b0;
    step_to(95);
    chk("t4_old_s3", led_2, 7'h5B);
    chk("t4_tick2", frame_tick, 1'b1);
    step_to(96);
    chk("t4_new_led1", led_1, 7'h66);
    chk("t4_new_led2", led_2, 7'h66);
    step_to(100);
    upd.upd_valid = 1'b1;
    upd.upd_data  = 32'h5555_5555;
    step_to(101);
    chk("t5_pending", upd.upd_ready, 1'b0);
    upd.upd_valid = 1'b0;
    step_to(106);
    chk("t5_slot2", digits, 8'h44);
    rst = 1'b0;
    #1;
    chk("t5_async_digits", digits, 8'h00);
    chk("t5_async_led1", led_1, 7'h00);
    chk("t5_async_led2", led_2, 7'h00);
    chk("t5_async_ready", upd.upd_ready, 1'b1);
    chk("t5_async_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    step_to(1);
    chk("t5_rel_digits", digits, 8'h00);
    chk("t5_rel_led1", led_1, 7'h3F);
    chk("t5_rel_ready", upd.upd_ready, 1'b1);
    step_to(2);
    chk("t5_rel_slot0", digits, 8'h11);
    step_to(16);
    chk("t5_discard_led1", led_1, 7'h3F);
    chk("t5_discard_led2", led_2, 7'h3F);
    step_to(20);
    upd.upd_valid = 1'b1;
    upd.upd_data  = 32'h0000_00A0;
    step_to(21);
    upd.upd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_to(32 + 4 * i);
      chk("t6_led1", led_1, E6_1[i]);
      chk("t6_led2", led_2, E6_2[i]);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
